// File: rtl/alu_ctrl.sv
// alu_ctrl: four-state IDLE/READ/EXEC/WB sequencer for register-file read, ALU execute and write-back.
// Define ALU_CTRL_FLAGS_EN to add the zf/nf result flag outputs.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  ra_addr,
    output logic [2:0]  rb_addr,
    input  logic [15:0] ra_data,
    input  logic [15:0] rb_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_com,
    input  logic [15:0] alu_y,
    output logic        wr_en,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        err
`ifdef ALU_CTRL_FLAGS_EN
    ,
    output logic        zf,
    output logic        nf
`endif
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t state_q, state_d;
    logic [15:0] instr_q, res_q, imm;
    logic [2:0] rd, rs, com;
    logic is_r, is_ldi, legal;
    assign is_r   = instr_q[15:11] == 5'b00000 && instr_q[4:3] == 2'b00;
    assign is_ldi = instr_q[15:11] == 5'b01000;
    assign legal  = is_r || is_ldi;
    assign rd     = instr_q[10:8];
    assign rs     = instr_q[7:5];
    assign imm    = {{8{instr_q[7]}}, instr_q[7:0]};
    assign com    = is_ldi ? 3'b001 : instr_q[2:0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_valid) instr_q <= instr;
            if (state_q == EXEC) res_q <= alu_y;
        end
    end
    // Pulses are gated by rst_n so an aborted instruction never shows err or wr_en.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        ra_addr     = '0;
        rb_addr     = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_com     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        err         = 1'b0;
        busy        = state_q != IDLE;
        case (state_q)
            IDLE: begin
                instr_ready = rst_n;
                state_d     = instr_valid ? READ : IDLE;
            end
            READ: begin
                ra_addr = rd;
                rb_addr = rs;
                err     = rst_n && !legal;
                state_d = legal ? EXEC : IDLE;
            end
            EXEC: begin
                alu_a   = ra_data;
                alu_b   = is_ldi ? imm : rb_data;
                alu_com = com;
                state_d = WB;
            end
            WB: begin
                wr_en   = rst_n;
                wr_addr = rd;
                wr_data = res_q;
                state_d = IDLE;
            end
        endcase
    end
`ifdef ALU_CTRL_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zf <= 1'b0;
            nf <= 1'b0;
        end else if (state_q == WB) begin
            zf <= res_q == 16'h0000;
            nf <= res_q[15];
        end
    end
`endif
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed and random checks of alu_ctrl against an instruction-level reference model.
// Build with ALU_CTRL_FLAGS_EN defined to also check zf/nf.
module tb_alu_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic instr_ready, wr_en, busy, err;
    logic [2:0] ra_addr, rb_addr, alu_com, wr_addr;
    logic [15:0] ra_data = '0, rb_data = '0, alu_a, alu_b, alu_y, wr_data;
`ifdef ALU_CTRL_FLAGS_EN
    logic zf, nf;
`endif
    logic pl_en = 1'b0;
    logic [2:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] rf [8];
    logic [15:0] exp_rf [8];
    int checks = 0, errors = 0;

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_com(alu_com), .alu_y(alu_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
`ifdef ALU_CTRL_FLAGS_EN
        , .zf(zf), .nf(nf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            3'd0: return a & b;
            3'd1: return b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return a << 1;
            3'd5: return a >> 1;
            3'd6: return a + b;
            default: return a - b;
        endcase
    endfunction

    assign alu_y = alu_f(alu_com, alu_a, alu_b);

    // Register file with one-cycle read latency; preload port used only by the bench.
    always @(posedge clk) begin
        ra_data <= rf[ra_addr];
        rb_data <= rf[rb_addr];
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (wr_en) rf[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Instruction-level model: what the instruction should read and write.
    task automatic model(input logic [15:0] ins, output bit lg, output int rd, output int rs,
                         output logic [2:0] c, output logic [15:0] a, output logic [15:0] b,
                         output logic [15:0] res);
        int op, imm;
        op = int'(ins) / 2048;
        rd = (int'(ins) / 256) % 8;
        rs = (int'(ins) / 32) % 8;
        a = exp_rf[rd];
        lg = 1'b0;
        c = 3'd0;
        b = 16'h0000;
        res = 16'h0000;
        if (op == 8) begin
            imm = int'(ins) % 256;
            if (imm >= 128) imm -= 256;
            lg = 1'b1;
            c = 3'd1;
            b = 16'(imm);
            res = b;
        end else if (op == 0 && (int'(ins) / 8) % 4 == 0) begin
            lg = 1'b1;
            c = 3'(int'(ins) % 8);
            b = exp_rf[rs];
            res = alu_f(c, a, b);
        end
    endtask

    function automatic logic [15:0] gen_legal();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[15]) return {5'b01000, v[10:0]};
        return {5'b00000, v[10:5], 2'b00, v[2:0]};
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_ra"}, ra_addr, 0);
        chk({tag, "_rb"}, rb_addr, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_com"}, alu_com, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, instr_ready, 1);
    endtask

    // Called at a negedge; returns the observed write data (0 if none).
    task automatic run(input logic [15:0] ins, output logic [15:0] wd);
        bit lg;
        int rd, rs;
        logic [2:0] c;
        logic [15:0] a, b, res;
        wd = 16'h0000;
        wait_ready("run");
        model(ins, lg, rd, rs, c, a, b, res);
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        chk("read_busy", busy, 1);
        chk("read_ready", instr_ready, 0);
        chk("read_ra", ra_addr, 16'(rd));
        chk("read_rb", rb_addr, 16'(rs));
        chk("read_err", err, !lg);
        chk("read_wr_en", wr_en, 0);
        @(negedge clk);
        if (!lg) begin
            chk("ill_err_drop", err, 0);
            chk("ill_ready", instr_ready, 1);
            chk("ill_busy", busy, 0);
            chk("ill_wr_en", wr_en, 0);
            return;
        end
        chk("exec_com", alu_com, c);
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_wr_en", wr_en, 0);
        @(negedge clk);
        chk("wb_wr_en", wr_en, 1);
        chk("wb_addr", wr_addr, 16'(rd));
        chk("wb_data", wr_data, res);
        wd = wr_data;
        exp_rf[rd] = res;
        @(negedge clk);
        chk("post_wr_en", wr_en, 0);
        chk("post_ready", instr_ready, 1);
`ifdef ALU_CTRL_FLAGS_EN
        chk("zf", zf, res == 16'h0000);
        chk("nf", nf, res[15]);
`endif
    endtask

    initial begin
        logic [15:0] wd, v;
        int q_rd[$];
        logic [15:0] q_res[$];
        int last;
        bit lg;
        int rd, rs;
        logic [2:0] c;
        logic [15:0] a, b, res;
        for (int i = 0; i < 8; i++) begin
            v = (i == 1) ? 16'h0003 : (i == 2) ? 16'h0004 : (i == 3) ? 16'h1234 : 16'($urandom);
            pl_en = 1'b1;
            pl_addr = 3'(i);
            pl_data = v;
            exp_rf[i] = v;
            @(negedge clk);
        end
        pl_en = 1'b0;
        chk("rst_ready", instr_ready, 0);
        chk_quiet("rst");
`ifdef ALU_CTRL_FLAGS_EN
        chk("rst_zf", zf, 0);
        chk("rst_nf", nf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);
        chk_quiet("post_rst");

        run(16'h0146, wd);
        chk("add_r1_r2", wd, 16'h0007);
        run(16'h45F0, wd);
        chk("ldi_neg", wd, 16'hFFF0);
        run(16'h0367, wd);
        chk("sub_self", wd, 16'h0000);
        run(16'hF800, wd);
        run(16'h0018, wd);

        for (int i = 0; i < 30; i++) begin
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : gen_legal();
            run(v, wd);
        end

        // Continuous valid: only the instruction present at each accept edge is taken.
        last = -1;
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            if (wr_en) begin
                chk("cont_write_expected", q_rd.size() > 0, 1);
                if (q_rd.size() > 0) begin
                    chk("cont_addr", wr_addr, 16'(q_rd.pop_front()));
                    chk("cont_data", wr_data, q_res.pop_front());
                end
            end
            if (cyc >= 40) instr_valid = 1'b0;
            instr = gen_legal();
            if (instr_ready && instr_valid) begin
                model(instr, lg, rd, rs, c, a, b, res);
                exp_rf[rd] = res;
                q_rd.push_back(rd);
                q_res.push_back(res);
                if (last >= 0) chk("cont_gap", 16'(cyc - last), 16'd4);
                last = cyc;
            end
            @(negedge clk);
        end
        chk("cont_drained", 16'(q_rd.size()), 0);

        // Reset during EXEC aborts the instruction.
        wait_ready("abort");
        instr = gen_legal();
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", instr_ready, 0);
        chk_quiet("abort");
`ifdef ALU_CTRL_FLAGS_EN
        chk("abort_zf", zf, 0);
        chk("abort_nf", nf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", instr_ready, 1);
        chk_quiet("abort_after");
        for (int i = 0; i < 4; i++) begin
            run(gen_legal(), wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
